// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control front-end for the 0-59 stopwatch counter chain.
//
// Synchronises and debounces the raw start/stop and lap/clear buttons, turns
// debounced rising edges into single-cycle press pulses and runs the
// IDLE/RUN/STOP state machine that drives the counter run-enable, its
// active-low clear pulse and the display-hold flag.
//
// Optional feature macro: LAP_HOLD_EN
//   defined   : lap/clear in RUN toggles hold (display freeze while counting);
//               in STOP, lap/clear first releases a pending hold.
//   undefined : hold is tied to 0, lap/clear in RUN is ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synced cycles before a debounced level flips (>=2)
//   CLR_CYCLES       length of the clr_n low pulse in clk cycles (>=1)
//
// Ports:
//   clk     in   system clock, posedge
//   clr     in   asynchronous active-high reset
//   btn_ss  in   raw start/stop button (async, bouncy)
//   btn_lc  in   raw lap/clear button (async, bouncy)
//   run     out  counter enable, 1 = counting
//   clr_n   out  active-low clear pulse to the counter
//   hold    out  display freeze request
//   state   out  FSM state: 00 IDLE, 01 RUN, 10 STOP
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned CLR_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic       run,
  output logic       clr_n,
  output logic       hold,
  output logic [1:0] state
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  // One extra count so that after reset release clr_n stays low for
  // CLR_CYCLES full posedges before rising.
  localparam int unsigned CC_W  = $clog2(CLR_CYCLES + 2);
  localparam int unsigned N_BTN = 2;
  localparam int unsigned BTN_SS = 0;
  localparam int unsigned BTN_LC = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_e;

  logic [N_BTN-1:0]           raw;
  logic [N_BTN-1:0]           meta_q;
  logic [N_BTN-1:0]           sync_q;
  logic [N_BTN-1:0]           db_q;
  logic [N_BTN-1:0]           db_d;
  logic [N_BTN-1:0]           press_q;
  logic [N_BTN-1:0]           press_d;
  logic [N_BTN-1:0][DB_W-1:0] cnt_q;
  logic [N_BTN-1:0][DB_W-1:0] cnt_d;

  state_e          state_q;
  state_e          state_d;
  logic            run_q;
  logic            run_d;
  logic            hold_q;
  logic            hold_d;
  logic            clr_n_q;
  logic            clr_n_d;
  logic [CC_W-1:0] clr_cnt_q;
  logic [CC_W-1:0] clr_cnt_d;
  logic            clr_trig;
  logic            clr_ending;
  logic            ss_p;
  logic            lc_p;

  assign raw  = {btn_lc, btn_ss};
  assign ss_p = press_q[BTN_SS];
  assign lc_p = press_q[BTN_LC];

  // Debounce: count while synced differs from the debounced level, flip on the
  // DEBOUNCE_CYCLES-th differing cycle; any agreeing cycle restarts the count.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
      press_d[i] = db_d[i] & ~db_q[i];
    end
  end

  // A start request is only honoured once the clear pulse is on its last
  // cycle, so run never overlaps a low clr_n.
  assign clr_ending = (clr_cnt_q <= CC_W'(1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    hold_d    = hold_q;
    clr_cnt_d = clr_cnt_q;
    clr_n_d   = clr_n_q;
    clr_trig  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ss_p && clr_ending) begin
          state_d = S_RUN;
          run_d   = 1'b1;
        end else if (lc_p) begin
          clr_trig = 1'b1;
        end
      end
      S_RUN: begin
        if (ss_p) begin
          state_d = S_STOP;
          run_d   = 1'b0;
        end else if (lc_p) begin
`ifdef LAP_HOLD_EN
          hold_d = ~hold_q;
`else
          hold_d = hold_q;
`endif
        end
      end
      S_STOP: begin
        if (lc_p) begin
`ifdef LAP_HOLD_EN
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            state_d  = S_IDLE;
            clr_trig = 1'b1;
          end
`else
          state_d  = S_IDLE;
          clr_trig = 1'b1;
`endif
        end else if (ss_p) begin
          state_d = S_RUN;
          run_d   = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        clr_trig = 1'b1;
      end
    endcase

    if (state_d == S_IDLE) begin
      run_d  = 1'b0;
      hold_d = 1'b0;
    end
`ifndef LAP_HOLD_EN
    hold_d = 1'b0;
`endif

    // Clear pulse: a trigger (re)loads the full length.
    if (clr_trig) begin
      clr_cnt_d = CC_W'(CLR_CYCLES);
    end else if (clr_cnt_q != '0) begin
      clr_cnt_d = clr_cnt_q - CC_W'(1);
    end
    clr_n_d = (clr_cnt_d == '0);
  end

  // All state: synchronisers, debouncers, FSM and outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_q    <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      hold_q    <= 1'b0;
      clr_n_q   <= 1'b0;
      clr_cnt_q <= CC_W'(CLR_CYCLES + 1);
    end else begin
      meta_q    <= raw;
      sync_q    <= meta_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      run_q     <= run_d;
      hold_q    <= hold_d;
      clr_n_q   <= clr_n_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run   = run_q;
  assign hold  = hold_q;
  assign clr_n = clr_n_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DEBOUNCE_CYCLES=4, CLR_CYCLES=2).
// A second instance with a long clear pulse exercises pulse restart.
module tb_stopwatch_ctrl;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STOP = 2'b10;
`ifdef LAP_HOLD_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lc = 1'b0;
  logic       run, clr_n, hold;
  logic [1:0] state;
  logic       run_l, clr_n_l, hold_l;
  logic [1:0] state_l;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int c;
  int r;

  typedef struct {
    int         at;
    string      tag;
    bit         sel;
    logic [4:0] exp;
  } sb_t;
  sb_t sb[$];

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .CLR_CYCLES(2)) u_dut (
    .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .run(run), .clr_n(clr_n), .hold(hold), .state(state)
  );

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .CLR_CYCLES(10)) u_long (
    .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .run(run_l), .clr_n(clr_n_l), .hold(hold_l), .state(state_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, obs[4:0], exp[4:0]);
    end
  endtask

  function automatic logic [4:0] v(input logic [1:0] s, input logic rn, input logic h,
                                   input logic cn);
    return {s, rn, h, cn};
  endfunction

  // Expected {state,run,hold,clr_n} for the negedge of cycle 'at', kept sorted.
  task automatic push(input int at, input string tag, input bit sel, input logic [4:0] exp);
    sb_t e;
    int  idx;
    e.at = at; e.tag = tag; e.sel = sel; e.exp = exp;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      if (e.sel) check(e.tag, 32'({state_l, run_l, hold_l, clr_n_l}), 32'(e.exp));
      else       check(e.tag, 32'({state, run, hold, clr_n}), 32'(e.exp));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Raw press of 'width' cycles, then idle long enough for release debounce.
  task automatic press(input logic ss, input logic lc, input int width);
    btn_ss = ss;
    btn_lc = lc;
    step(width);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    step(14);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    // Reset release: clr_n low for two posedges, then high.
    r = cyc;
    push(r,     "rst_val",   0, v(IDLE, 0, 0, 0));
    push(r + 2, "rst_clrn2", 0, v(IDLE, 0, 0, 0));
    push(r + 3, "rst_clrn3", 0, v(IDLE, 0, 0, 1));
    push(r + 10, "rst_long10", 1, v(IDLE, 0, 0, 0));
    push(r + 11, "rst_long11", 1, v(IDLE, 0, 0, 1));
    clr = 1'b0;
    step(14);

    // Bounce 1,0,1,0,1 then a 3-cycle glitch: no press.
    c = cyc;
    push(c + 14, "bounce_idle", 0, v(IDLE, 0, 0, 1));
    for (int i = 0; i < 5; i++) begin
      btn_ss = (i % 2 == 0);
      step(1);
    end
    btn_ss = 1'b0;
    step(12);
    c = cyc;
    push(c + 12, "glitch_idle", 0, v(IDLE, 0, 0, 1));
    press(1'b1, 1'b0, 3);

    // Clean 10-cycle press: start on cycle 7, exactly one pulse.
    c = cyc;
    push(c + 6,  "start_pre",  0, v(IDLE, 0, 0, 1));
    push(c + 7,  "start_run",  0, v(RUN, 1, 0, 1));
    push(c + 22, "start_once", 0, v(RUN, 1, 0, 1));
    press(1'b1, 1'b0, 10);

    // Lap in RUN.
    c = cyc;
    push(c + 6, "lap_pre", 0, v(RUN, 1, 0, 1));
    push(c + 7, "lap_run", 0, v(RUN, 1, LAP, 1));
    press(1'b0, 1'b1, 4);

    // Stop.
    c = cyc;
    push(c + 6, "stop_pre", 0, v(RUN, 1, LAP, 1));
    push(c + 7, "stop",     0, v(STOP, 0, LAP, 1));
    press(1'b1, 1'b0, 4);

`ifdef LAP_HOLD_EN
    c = cyc;
    push(c + 7, "unhold", 0, v(STOP, 0, 0, 1));
    press(1'b0, 1'b1, 4);
`endif

    // Clear from STOP: IDLE with a 2-cycle clr_n pulse.
    c = cyc;
    push(c + 6, "clear_pre", 0, v(STOP, 0, 0, 1));
    push(c + 7, "clear_lo1", 0, v(IDLE, 0, 0, 0));
    push(c + 8, "clear_lo2", 0, v(IDLE, 0, 0, 0));
    push(c + 9, "clear_hi",  0, v(IDLE, 0, 0, 1));
    press(1'b0, 1'b1, 4);

    // Two lc presses in IDLE: each retriggers; long pulse restarts in flight.
    c = cyc;
    push(c + 7,  "retrig_a_lo", 0, v(IDLE, 0, 0, 0));
    push(c + 9,  "retrig_a_hi", 0, v(IDLE, 0, 0, 1));
    push(c + 15, "retrig_b_lo1", 0, v(IDLE, 0, 0, 0));
    push(c + 16, "retrig_b_lo2", 0, v(IDLE, 0, 0, 0));
    push(c + 17, "retrig_b_hi", 0, v(IDLE, 0, 0, 1));
    push(c + 17, "long_restart", 1, v(IDLE, 0, 0, 0));
    push(c + 24, "long_lo",      1, v(IDLE, 0, 0, 0));
    push(c + 25, "long_hi",      1, v(IDLE, 0, 0, 1));
    btn_lc = 1'b1; step(4);
    btn_lc = 1'b0; step(4);
    btn_lc = 1'b1; step(4);
    btn_lc = 1'b0; step(20);

    // Simultaneous in STOP: clear wins.
    c = cyc;
    push(c + 7, "sim_go_run", 0, v(RUN, 1, 0, 1));
    press(1'b1, 1'b0, 4);
    c = cyc;
    push(c + 7, "sim_go_stop", 0, v(STOP, 0, 0, 1));
    press(1'b1, 1'b0, 4);
    c = cyc;
    push(c + 7, "sim_stop_clr", 0, v(IDLE, 0, 0, 0));
    push(c + 9, "sim_stop_end", 0, v(IDLE, 0, 0, 1));
    press(1'b1, 1'b1, 4);

    // Simultaneous in RUN: stop wins, hold unchanged.
    c = cyc;
    push(c + 7, "sim_run_go", 0, v(RUN, 1, 0, 1));
    press(1'b1, 1'b0, 4);
`ifdef LAP_HOLD_EN
    c = cyc;
    push(c + 7, "sim_run_hold", 0, v(RUN, 1, 1, 1));
    press(1'b0, 1'b1, 4);
`endif
    c = cyc;
    push(c + 7,  "sim_run_stop", 0, v(STOP, 0, LAP, 1));
    push(c + 12, "sim_run_stay", 0, v(STOP, 0, LAP, 1));
    press(1'b1, 1'b1, 4);

    // Reset mid-debounce while RUN; held lc then gives a fresh clear pulse.
    c = cyc;
    push(c + 7, "mid_go_run", 0, v(RUN, 1, LAP, 1));
    press(1'b1, 1'b0, 4);
    btn_lc = 1'b1;
    step(3);
    push(cyc, "mid_rst", 0, v(IDLE, 0, 0, 0));
    clr = 1'b1;
    step(1);
    r = cyc;
    clr = 1'b0;
    push(r + 2, "mid_clrn2", 0, v(IDLE, 0, 0, 0));
    push(r + 3, "mid_clrn3", 0, v(IDLE, 0, 0, 1));
    push(r + 6, "mid_db_pre", 0, v(IDLE, 0, 0, 1));
    push(r + 7, "mid_db_lo",  0, v(IDLE, 0, 0, 0));
    push(r + 9, "mid_db_hi",  0, v(IDLE, 0, 0, 1));
    step(12);
    btn_lc = 1'b0;
    step(14);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control front-end for the 0–59 stopwatch counter chain. Synchronises and debounces two raw push-buttons (start/stop, lap/clear) and runs a small state machine. The state machine drives the counter's run-enable (pause) input, its active-low clear input, and a display-hold flag for the seven-segment path. Sits directly upstream of the counter/decoder stage, in the fast clock domain, ahead of the frequency divider.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable clk cycles required before a debounced level changes; ≥2; counter width = clog2(DEBOUNCE_CYCLES+1)
CLR_CYCLES, 2, length in clk cycles of the clr_n low pulse; ≥1

Ports:
clk  input  1  system clock, all logic on posedge
clr  input  1  reset, asynchronous, active-high
btn_ss  input  1  raw start/stop button, async, active-high, bouncy
btn_lc  input  1  raw lap/clear button, async, active-high, bouncy
run  output  1  counter enable, 1 = counting; gates the divided clock as the counter's pause input
clr_n  output  1  active-low clear pulse to the counter
hold  output  1  display freeze request, 1 = display latches the current value
state  output  2  FSM state, 00 IDLE, 01 RUN, 10 STOP; 11 is unused

Behaviour:
- Reset (clr=1, async): state=IDLE, run=0, hold=0, clr_n=0, synchronisers and debounced levels=0, debounce counters=0.
- After clr falls, clr_n stays 0 for exactly CLR_CYCLES further posedges, then goes 1.
- Synchroniser: 2 flops per button. Raw to synced latency is 2 cycles.
- Debounce, per button:
  - While synced ≠ debounced level, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter resets to 0.
  - Any cycle with synced = debounced resets the counter to 0.
- Press pulse: 1-cycle pulse (ss_p, lc_p) on a 0→1 transition of the debounced level. A release produces nothing.
- Total press latency: 2 + DEBOUNCE_CYCLES cycles from a clean raw edge to the pulse; the FSM acts on the following posedge.
- FSM transitions (registered; run, hold and clr_n are registered, no combinational paths from inputs):
  - IDLE: ss_p → RUN, run=1. lc_p → stay IDLE, retrigger the clr_n pulse.
  - RUN: ss_p → STOP, run=0; ss_p has priority over a simultaneous lc_p, which is dropped. lc_p alone → lap handling (see Optional Feature).
  - STOP: lc_p takes priority over a simultaneous ss_p.
    - lc_p with hold=1 → hold=0, stay STOP.
    - lc_p with hold=0 → IDLE, clr_n pulse.
    - ss_p alone → RUN, run=1, hold unchanged.
- clr_n pulse:
  - Low for exactly CLR_CYCLES cycles, starting the cycle after the triggering edge.
  - A retrigger during a pulse restarts the full CLR_CYCLES count.
  - run is 0 throughout any pulse.
- hold: forced to 0 on every entry to IDLE.
- Reset asserted mid-pulse or mid-debounce: everything returns to reset values immediately.
- A held button produces exactly one press pulse, no auto-repeat.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no pulse.

Optional Feature:
LAP_HOLD_EN.
- Defined: in RUN, lc_p toggles hold; run is unaffected, so the counter keeps counting while the display is frozen. STOP handling as above.
- Undefined: hold is tied to 0; lc_p in RUN is ignored; in STOP, lc_p always → IDLE with a clr_n pulse.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CLR_CYCLES=2.
- Reset release: clr 1→0 → clr_n=0 for 2 posedges then 1; run=0, hold=0, state=00.
- Clean press: btn_ss held high 10 cycles in IDLE → ss_p exactly 6 cycles after the raw edge; next posedge state=01, run=1; one pulse only.
- Bounce: btn_ss toggles 1,0,1,0,1 at 1-cycle intervals, then stays 0 → no ss_p, state stays IDLE. A 3-cycle-wide high glitch also → no pulse.
- Stop and clear: IDLE → ss press → RUN → ss press → STOP (run=0) → lc press → state=00, clr_n low exactly 2 cycles. A second lc press during that pulse restarts the pulse to 2 full cycles.
- Simultaneous: debounced ss and lc rise together in STOP → state=00 with a clr pulse. Same in RUN → state=10, hold unchanged.
- LAP_HOLD_EN defined: RUN → lc press → hold=1, run=1 → ss press → STOP, hold=1 → lc → hold=0, state=10 → lc → state=00 with clr pulse. Undefined: lc in RUN leaves hold=0, state=01.
